// File: rtl/demux_pkg.sv
// Shared types and default widths for the registered 1:2 stream demultiplexer.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package demux_pkg;

    // Route FSM: IDLE follows S, LOCKk pins the route until a packet's last beat.
    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        LOCK0 = 2'd1,
        LOCK1 = 2'd2
    } demux_state_t;

    localparam int DEMUX_WIDTH = 8;
    localparam int DEMUX_CNT_W = 8;

endpackage

// File: rtl/out_slot.sv
// One-entry valid/ready output register holding {data, last}.
// Latency: a beat loaded at edge n is presented in the cycle after edge n.
// Backpressure: holds its contents while valid && !ready; the owner must load only when empty or draining.
//
// Ports:
//   clk, rst         clock, synchronous active-high reset
//   load             write din/din_last and set valid at the next edge
//   din, din_last    beat to store
//   ready            consumer ready; with valid forms the drain handshake
//   valid            slot holds a beat
//   dout, dout_last  stored beat
module out_slot
    import demux_pkg::*;
#(
    parameter int WIDTH = DEMUX_WIDTH
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             load,
    input  logic [WIDTH-1:0] din,
    input  logic             din_last,
    input  logic             ready,
    output logic             valid,
    output logic [WIDTH-1:0] dout,
    output logic             dout_last
);

    always_ff @(posedge clk) begin
        if (rst) begin
            valid     <= 1'b0;
            dout      <= '0;
            dout_last <= 1'b0;
        end else if (load) begin
            // Covers both an empty slot and a same-cycle drain plus refill.
            valid     <= 1'b1;
            dout      <= din;
            dout_last <= din_last;
        end else if (valid && ready) begin
            // Data is left in place after a drain; only valid drops.
            valid     <= 1'b0;
        end
    end

endmodule

// File: rtl/demux1_2_reg.sv
// Registered 1:2 stream demultiplexer with packet-level route lock and per-output packet counters.
// Latency: one cycle from input accept to Yk_valid; 1 beat/cycle when the target output is ready.
// Backpressure: I_ready follows the target slot only; a stalled target blocks the input even if the other output is free.
//
// Ports:
//   clk, rst                     clock, synchronous active-high reset
//   I, I_last, I_valid, I_ready  input stream (I_ready is the only combinational output)
//   S                            route select, 0 = Y0, 1 = Y1, honoured only between packets
//   Yk, Yk_last, Yk_valid, Yk_ready  output streams k = 0, 1
//   cnt0, cnt1                   wrapping count of packets delivered on Y0 / Y1
module demux1_2_reg
    import demux_pkg::*;
#(
    parameter int WIDTH = DEMUX_WIDTH,
    parameter int CNT_W = DEMUX_CNT_W
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] I,
    input  logic             I_last,
    input  logic             I_valid,
    output logic             I_ready,
    input  logic             S,
    output logic [WIDTH-1:0] Y0,
    output logic             Y0_last,
    output logic             Y0_valid,
    input  logic             Y0_ready,
    output logic [WIDTH-1:0] Y1,
    output logic             Y1_last,
    output logic             Y1_valid,
    input  logic             Y1_ready,
    output logic [CNT_W-1:0] cnt0,
    output logic [CNT_W-1:0] cnt1
);

    demux_state_t state;
    logic         target;
    logic         tgt_valid;
    logic         tgt_ready;
    logic         accept;
    logic         load0;
    logic         load1;

    // Route target: S only matters between packets.
    always_comb begin
        target = S;
        case (state)
            LOCK0:   target = 1'b0;
            LOCK1:   target = 1'b1;
            default: target = S;
        endcase
    end

    assign tgt_valid = target ? Y1_valid : Y0_valid;
    assign tgt_ready = target ? Y1_ready : Y0_ready;

    // Ready is independent of I_valid so upstream can gate valid on it freely.
    assign I_ready = !rst && (!tgt_valid || tgt_ready);
    assign accept  = I_valid && I_ready;
    assign load0   = accept && !target;
    assign load1   = accept &&  target;

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
        end else if (accept) begin
            case (state)
                IDLE: begin
                    // A single-beat packet never leaves IDLE.
                    if (!I_last) begin
                        state <= S ? LOCK1 : LOCK0;
                    end
                end
                LOCK0, LOCK1: begin
                    if (I_last) begin
                        state <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    out_slot #(.WIDTH(WIDTH)) u_slot0 (
        .clk       (clk),
        .rst       (rst),
        .load      (load0),
        .din       (I),
        .din_last  (I_last),
        .ready     (Y0_ready),
        .valid     (Y0_valid),
        .dout      (Y0),
        .dout_last (Y0_last)
    );

    out_slot #(.WIDTH(WIDTH)) u_slot1 (
        .clk       (clk),
        .rst       (rst),
        .load      (load1),
        .din       (I),
        .din_last  (I_last),
        .ready     (Y1_ready),
        .valid     (Y1_valid),
        .dout      (Y1),
        .dout_last (Y1_last)
    );

    // A packet counts as delivered when its last beat leaves the slot.
    always_ff @(posedge clk) begin
        if (rst) begin
            cnt0 <= '0;
            cnt1 <= '0;
        end else begin
            if (Y0_valid && Y0_ready && Y0_last) begin
                cnt0 <= cnt0 + 1'b1;
            end
            if (Y1_valid && Y1_ready && Y1_last) begin
                cnt1 <= cnt1 + 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_demux1_2_reg.sv
// Randomised and directed bench for demux1_2_reg against a queue-based reference model.
// Latency: n/a.
// Backpressure: drives Yk_ready directly, both directed and random.
module tb_demux1_2_reg;
    import demux_pkg::*;

    logic       clk = 1'b0;
    always #5 clk = ~clk;

    logic       rst;
    logic [7:0] din;
    logic       din_last;
    logic       din_vld;
    logic       sel;
    logic       y0_rdy;
    logic       y1_rdy;

    logic       in_rdy,  w_in_rdy;
    logic [7:0] y0, y1, w_y0, w_y1;
    logic       y0_last, y1_last, w_y0_last, w_y1_last;
    logic       y0_vld, y1_vld, w_y0_vld, w_y1_vld;
    logic [7:0] c0, c1;
    logic [1:0] w_c0, w_c1;

    demux1_2_reg dut (
        .clk(clk), .rst(rst), .I(din), .I_last(din_last), .I_valid(din_vld), .I_ready(in_rdy),
        .S(sel), .Y0(y0), .Y0_last(y0_last), .Y0_valid(y0_vld), .Y0_ready(y0_rdy),
        .Y1(y1), .Y1_last(y1_last), .Y1_valid(y1_vld), .Y1_ready(y1_rdy),
        .cnt0(c0), .cnt1(c1)
    );

    // Same stimulus, narrow counters: exercises the wrap.
    demux1_2_reg #(.WIDTH(8), .CNT_W(2)) u_wrap (
        .clk(clk), .rst(rst), .I(din), .I_last(din_last), .I_valid(din_vld), .I_ready(w_in_rdy),
        .S(sel), .Y0(w_y0), .Y0_last(w_y0_last), .Y0_valid(w_y0_vld), .Y0_ready(y0_rdy),
        .Y1(w_y1), .Y1_last(w_y1_last), .Y1_valid(w_y1_vld), .Y1_ready(y1_rdy),
        .cnt0(w_c0), .cnt1(w_c1)
    );

    // Reference model: per-output queue of beats in flight, last presented beat,
    // current packet route (-1 = between packets) and delivered-packet totals.
    typedef struct packed {
        logic [7:0] d;
        logic       l;
    } beat_t;

    beat_t      q0[$];
    beat_t      q1[$];
    logic [7:0] sh0, sh1;
    logic       shl0, shl1;
    int         route;
    int         n0, n1;

    int         errors = 0;
    int         checks = 0;
    int         cyc_count = 0;
    logic       acc_q;
    logic       pend;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    task automatic model_clear();
        q0.delete();
        q1.delete();
        sh0 = '0; sh1 = '0; shl0 = 1'b0; shl1 = 1'b0;
        route = -1;
        n0 = 0; n1 = 0;
    endtask

    // One clock: check outputs on the falling edge, advance the model on the rising edge.
    task automatic cycle();
        int         tgt;
        logic       v0, v1, exp_rdy, acc, dr0, dr1;
        logic [1:0] exp_st;
        beat_t      b;
        @(negedge clk);
        v0 = (q0.size() != 0);
        v1 = (q1.size() != 0);
        chk("y0_valid", y0_vld, v0);
        chk("y1_valid", y1_vld, v1);
        chk("y0_data", y0, sh0);
        chk("y1_data", y1, sh1);
        chk("y0_last", y0_last, shl0);
        chk("y1_last", y1_last, shl1);
        chk("cnt0", c0, n0 % 256);
        chk("cnt1", c1, n1 % 256);
        chk("wrap_cnt0", w_c0, n0 % 4);
        chk("wrap_cnt1", w_c1, n1 % 4);
        exp_st = (route < 0) ? IDLE : ((route == 0) ? LOCK0 : LOCK1);
        chk("fsm", dut.state, exp_st);
        tgt = (route < 0) ? int'(sel) : route;
        exp_rdy = !rst && ((tgt == 0) ? (!v0 || y0_rdy) : (!v1 || y1_rdy));
        chk("in_ready", in_rdy, exp_rdy);
        chk("wrap_in_ready", w_in_rdy, exp_rdy);
        acc  = din_vld && exp_rdy;
        dr0  = v0 && y0_rdy;
        dr1  = v1 && y1_rdy;
        pend = din_vld && !acc;
        acc_q = acc;
        @(posedge clk);
        cyc_count++;
        if (rst) begin
            model_clear();
        end else begin
            if (dr0) begin
                if (q0[0].l) n0++;
                void'(q0.pop_front());
            end
            if (dr1) begin
                if (q1[0].l) n1++;
                void'(q1.pop_front());
            end
            if (acc) begin
                b.d = din;
                b.l = din_last;
                if (tgt == 0) begin
                    q0.push_back(b); sh0 = din; shl0 = din_last;
                end else begin
                    q1.push_back(b); sh1 = din; shl1 = din_last;
                end
                if (route < 0 && !din_last) route = tgt;
                else if (route >= 0 && din_last) route = -1;
            end
        end
        #1;
    endtask

    // Present a beat until accepted (bounded).
    task automatic send(input logic s, input logic [7:0] d, input logic l);
        logic done;
        done = 1'b0;
        sel = s; din = d; din_last = l; din_vld = 1'b1;
        for (int k = 0; k < 40 && !done; k++) begin
            cycle();
            if (acc_q) done = 1'b1;
        end
        if (!done) chk("send_timeout", 32'd0, 32'd1);
    endtask

    task automatic idle(input int n);
        din_vld = 1'b0;
        for (int k = 0; k < n; k++) cycle();
    endtask

    int start;
    int seq[5] = '{1, 2, 3, 0, 1};

    initial begin
        rst = 1'b1; din = '0; din_last = 1'b0; din_vld = 1'b0; sel = 1'b0;
        y0_rdy = 1'b1; y1_rdy = 1'b1; pend = 1'b0; acc_q = 1'b0;
        model_clear();
        @(posedge clk); #1;
        cycle();                       // reset state checked against cleared model
        rst = 1'b0;

        // Single-beat packets to each output.
        send(1'b0, 8'hA5, 1'b1);
        send(1'b1, 8'h3C, 1'b1);
        idle(2);
        chk("single_cnt0", c0, 32'd1);
        chk("single_cnt1", c1, 32'd1);

        // Packet lock: S flips after the first beat, whole packet stays on Y0.
        send(1'b0, 8'h01, 1'b0);
        send(1'b1, 8'h02, 1'b0);
        send(1'b1, 8'h03, 1'b0);
        send(1'b1, 8'h04, 1'b1);
        idle(2);
        chk("lock_cnt0", c0, 32'd2);
        chk("lock_cnt1", c1, 32'd1);

        // Backpressure on Y1.
        y1_rdy = 1'b0;
        send(1'b1, 8'h55, 1'b1);
        sel = 1'b1; din = 8'h66; din_last = 1'b1; din_vld = 1'b1;
        for (int k = 0; k < 3; k++) begin
            cycle();
            chk("bp_blocked", acc_q, 1'b0);
        end
        chk("bp_y1_held", y1, 32'h55);
        idle(1);
        start = cyc_count;
        send(1'b0, 8'h77, 1'b1);
        chk("bp_other_free", cyc_count - start, 32'd1);
        y1_rdy = 1'b1;
        start = cyc_count;
        for (int k = 0; k < 16; k++) send(1'b1, 8'h10 + 8'(k), (k == 15));
        chk("stream_cycles", cyc_count - start, 32'd16);
        idle(2);

        // Same-cycle drain and refill on Y0.
        start = cyc_count;
        for (int k = 0; k < 8; k++) send(1'b0, 8'h80 + 8'(k), 1'b1);
        chk("refill_cycles", cyc_count - start, 32'd8);
        idle(2);

        // Reset in the middle of a Y1 packet.
        send(1'b1, 8'hB1, 1'b0);
        send(1'b1, 8'hB2, 1'b0);
        rst = 1'b1; din_vld = 1'b0;
        cycle();
        rst = 1'b0;
        chk("rst_y0_valid", y0_vld, 1'b0);
        chk("rst_y1_valid", y1_vld, 1'b0);
        chk("rst_y1_data", y1, 32'd0);
        chk("rst_cnt1", c1, 32'd0);
        chk("rst_fsm", dut.state, IDLE);
        send(1'b0, 8'hC1, 1'b1);
        idle(2);
        chk("post_rst_cnt0", c0, 32'd1);
        chk("post_rst_cnt1", c1, 32'd0);

        // Counter wrap on the CNT_W=2 instance.
        rst = 1'b1; din_vld = 1'b0;
        cycle();
        rst = 1'b0;
        for (int k = 0; k < 5; k++) begin
            send(1'b0, 8'hD0 + 8'(k), 1'b1);
            idle(1);
            chk("wrap_seq", w_c0, seq[k]);
        end

        // Random traffic.
        for (int k = 0; k < 600; k++) begin
            rst      = ($urandom_range(0, 79) == 0);
            din_vld  = ($urandom_range(0, 3) != 0);
            din      = 8'($urandom);
            din_last = ($urandom_range(0, 2) == 0);
            y0_rdy   = ($urandom_range(0, 3) != 0);
            y1_rdy   = ($urandom_range(0, 3) != 0);
            if (!pend) sel = 1'($urandom);
            cycle();
        end
        rst = 1'b0;
        idle(2);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/demux1_2_reg.md
# demux1_2_reg

Registered 1-to-2 stream demultiplexer: the routing counterpart to the team's 2:1 mux. Each beat accepted on input `I` is steered to output `Y0` or `Y1` according to select `S`, through a one-entry register per output. A packet lock holds the route from a packet's first beat through its `last` beat. Sits wherever a single stream fans out to two consumers; per-output packet counters support debug.

## Interface
Parameters:
- `WIDTH`, 8: data width of `I`, `Y0` and `Y1`.
- `CNT_W`, 8: width of the per-output packet counters.

Ports:
- `clk`  in  1  rising-edge clock.
- `rst`  in  1  synchronous, active-high reset.
- `I`  in  WIDTH  input data.
- `I_last`  in  1  marks the final beat of a packet.
- `I_valid`  in  1  input beat present.
- `I_ready`  out  1  input beat accepted when `I_valid && I_ready`.
- `S`  in  1  route select, 0 = `Y0`, 1 = `Y1`; sampled only in IDLE.
- `Y0`, `Y1`  out  WIDTH  output data.
- `Y0_last`, `Y1_last`  out  1  registered copy of `I_last`.
- `Y0_valid`, `Y1_valid`  out  1  output beat present.
- `Y0_ready`, `Y1_ready`  in  1  consumer ready.
- `cnt0`, `cnt1`  out  CNT_W  packets fully delivered on `Y0` / `Y1`.

## Operation
- Target output, combinational:
  - IDLE: target = `S`.
  - LOCK0: target = 0, ignoring `S`.
  - LOCK1: target = 1, ignoring `S`.
- `I_ready = !rst && (!Yt_valid || Yt_ready)`, where t is the target. `I_ready` never depends on `I_valid`.
- Accept writes `I` and `I_last` into the target slot and sets that slot's valid. The non-target slot is unaffected.
- Output slot k:
  - Holds data stable while `Yk_valid && !Yk_ready`.
  - Clears valid on `Yk_valid && Yk_ready` unless refilled in the same cycle.
  - A same-cycle drain and refill leaves valid set, loaded with the new beat.
- FSM (`demux_state_t`):
  - IDLE, accept with `!I_last`: go to LOCK(S).
  - IDLE, accept with `I_last`: stay in IDLE (single-beat packet).
  - LOCKk, accept with `I_last`: go to IDLE.
  - LOCKk, otherwise: stay in LOCKk.
- No reordering and no bypass. A stalled target stalls the input even when the other output is free (head-of-line blocking).
- Counter k increments on `Yk_valid && Yk_ready && Yk_last`. It wraps from 2^CNT_W−1 to 0.
- Reset:
  - FSM returns to IDLE.
  - Both valids clear; `Y0`, `Y1`, `Y*_last` and both counters go to 0.
  - A partial packet in flight is dropped. The first beat after reset is treated as a new packet start.

## Timing
- Latency: beat accepted at edge n appears on `Yk` (`Yk_valid = 1`) in the cycle after edge n. Output data is registered.
- Throughput: 1 beat/cycle per stream when the target is always ready.
- Only `I_ready` is a combinational output (from `Yk_ready` and `S`). All other outputs are registered.
- In IDLE, a change of `S` changes which slot `I_ready` reflects within the same cycle. The upstream must hold `S` stable while `I_valid` is high and unaccepted.
- Reset takes effect at the first rising edge with `rst = 1`. All registered outputs hold reset values until the first edge with `rst = 0`.

## Structure
- Package `demux_pkg`:
  - `typedef enum logic [1:0] {IDLE, LOCK0, LOCK1} demux_state_t`.
  - Default widths `DEMUX_WIDTH = 8` and `DEMUX_CNT_W = 8`.
- Sub-module `out_slot`: one-entry valid/ready register holding `{data, last}`, with a load strobe and a drain handshake. Instantiated twice.
- The top level holds the FSM, `I_ready` generation and both counters.

## Test plan
- Single-beat packets: `S`=0, `I`=8'hA5, `last`=1, then `S`=1, `I`=8'h3C, `last`=1, both outputs ready.
  - Required: `Y0`=A5 one cycle after its accept, `Y1`=3C one cycle after its accept, `cnt0`=`cnt1`=1, FSM back in IDLE.
- Packet lock: 4-beat packet 01..04 with `S`=0 on beat 1, `S` toggled to 1 on beats 2–4.
  - Required: all 4 beats on `Y0` in order, nothing on `Y1`, `cnt0`=1.
- Backpressure: `Y1_ready`=0 with the `Y1` slot full, new beat targeting `Y1`.
  - Required: `I_ready`=0 and `Y1` data held stable.
  - Required: with `S`=0, `I_ready`=1.
  - Required: after `Y1_ready`=1, full-rate streaming 10..1F arrives without gaps or loss.
- Same-cycle drain and refill on `Y0` over 8 consecutive cycles.
  - Required: `Y0_valid` stays high and 8 distinct beats are delivered.
- Reset mid-packet: assert `rst` after beat 2 of a `Y1` packet.
  - Required: valids, data and counters are 0 and FSM is IDLE.
  - Required: a next packet with `S`=0 goes to `Y0`.
- Counter wrap: `CNT_W`=2, deliver 5 packets on `Y0`.
  - Required: `cnt0` sequence 1,2,3,0,1.
